// File: rtl/buffer_write.sv
// buffer_write: write side of the segmented packet buffer.
// Streams beats into RAM segments drawn from an internal free list.
module buffer_write #(
  parameter int SEGMENT_SIZE_W = 10,
  parameter int BUF_SEG_AW     = 10,
  parameter int ADDR_WIDTH     = BUF_SEG_AW + SEGMENT_SIZE_W,
  parameter int DATA_WIDTH     = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  input  logic                  s_tlast,
  output logic                  s_tready,
  output logic                  b_wen,
  output logic [ADDR_WIDTH-1:0] b_waddr,
  output logic [DATA_WIDTH-1:0] b_wdata,
  output logic [BUF_SEG_AW:0]   used_pointer,
  output logic                  used_pointer_valid,
  input  logic [BUF_SEG_AW-1:0] freed_pointer,
  input  logic                  freed_pointer_valid,
  output logic [BUF_SEG_AW:0]   free_count,
  output logic                  init_done,
  output logic                  err
);

  localparam int DEPTH = 1 << BUF_SEG_AW;
  localparam logic [BUF_SEG_AW:0] C_FULL =
    {1'b1, {BUF_SEG_AW{1'b0}}};
  localparam logic [BUF_SEG_AW:0] C_ONE = 1;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t r_state;
  state_t w_state_n;

  logic [BUF_SEG_AW-1:0] r_init_cnt;
  logic                  r_init_done;
  logic                  r_err;

  logic [BUF_SEG_AW-1:0] r_mem [DEPTH];
  logic [BUF_SEG_AW-1:0] r_wptr;
  logic [BUF_SEG_AW-1:0] r_rptr;
  logic [BUF_SEG_AW:0]   r_count;
  logic [BUF_SEG_AW:0]   w_count_n;
  logic [BUF_SEG_AW-1:0] r_rdata;
  logic                  r_pop_inflight;

  logic                  w_push_req;
  logic [BUF_SEG_AW-1:0] w_push_data;
  logic                  w_init_drop;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_ovf;
  logic                  w_pop;

  logic [BUF_SEG_AW-1:0] r_cur;
  logic [BUF_SEG_AW-1:0] r_nxt;
  logic                  r_cur_valid;
  logic                  r_nxt_valid;
  logic [BUF_SEG_AW-1:0] w_cur_n;
  logic [BUF_SEG_AW-1:0] w_nxt_n;
  logic                  w_cur_v_n;
  logic                  w_nxt_v_n;

  logic [SEGMENT_SIZE_W-1:0] r_loc;
  logic                      w_tready;
  logic                      w_accept;
  logic                      w_close;

  logic                  r_wen;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_up_valid;
  logic [BUF_SEG_AW:0]   r_up;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_push_req  = 1'b0;
    w_push_data = freed_pointer;
    w_init_drop = 1'b0;
    unique case (r_state)
      ST_INIT: begin
        w_push_req  = 1'b1;
        w_push_data = r_init_cnt;
        w_init_drop = freed_pointer_valid;
        if (r_init_cnt == '1) begin
          w_state_n = ST_RUN;
        end
      end
      ST_RUN: begin
        w_push_req = freed_pointer_valid;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_init_cnt  <= '0;
      r_init_done <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (r_state == ST_INIT) begin
        r_init_cnt <= r_init_cnt + BUF_SEG_AW'(1);
      end
      if (r_state == ST_INIT && w_state_n == ST_RUN) begin
        r_init_done <= 1'b1;
      end
      if (w_ovf || w_init_drop) begin
        r_err <= 1'b1;
      end
    end
  end

  assign w_full  = (r_count == C_FULL);
  assign w_empty = (r_count == '0);
  assign w_push  = w_push_req && !w_full;
  assign w_ovf   = w_push_req && w_full;

  // At most one pop in flight so the returning word always
  // finds an empty slot in cur or nxt.
  assign w_pop = (r_state == ST_RUN)
              && (!r_cur_valid || !r_nxt_valid)
              && !w_empty
              && !r_pop_inflight;

  always_comb begin
    w_count_n = r_count;
    if (w_push && !w_pop) begin
      w_count_n = r_count + C_ONE;
    end else if (!w_push && w_pop) begin
      w_count_n = r_count - C_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_count        <= '0;
      r_rdata        <= '0;
      r_pop_inflight <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + BUF_SEG_AW'(1);
      end
      if (w_pop) begin
        r_rptr  <= r_rptr + BUF_SEG_AW'(1);
        r_rdata <= r_mem[r_rptr];
      end
      r_count        <= w_count_n;
      r_pop_inflight <= w_pop;
    end
  end

  assign w_tready = (r_state == ST_RUN) && r_cur_valid;
  assign w_accept = s_tvalid && w_tready;
  assign w_close  = w_accept && (s_tlast || (r_loc == '1));

  always_comb begin
    w_cur_n   = r_cur;
    w_nxt_n   = r_nxt;
    w_cur_v_n = r_cur_valid;
    w_nxt_v_n = r_nxt_valid;
    if (w_close) begin
      if (r_nxt_valid) begin
        w_cur_n   = r_nxt;
        w_nxt_v_n = 1'b0;
      end else begin
        w_cur_v_n = 1'b0;
      end
    end
    if (r_pop_inflight) begin
      if (!w_cur_v_n) begin
        w_cur_n   = r_rdata;
        w_cur_v_n = 1'b1;
      end else begin
        w_nxt_n   = r_rdata;
        w_nxt_v_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur       <= '0;
      r_nxt       <= '0;
      r_cur_valid <= 1'b0;
      r_nxt_valid <= 1'b0;
    end else begin
      r_cur       <= w_cur_n;
      r_nxt       <= w_nxt_n;
      r_cur_valid <= w_cur_v_n;
      r_nxt_valid <= w_nxt_v_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_loc      <= '0;
      r_wen      <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_up_valid <= 1'b0;
      r_up       <= '0;
    end else begin
      r_wen      <= w_accept;
      r_up_valid <= w_close;
      if (w_accept) begin
        r_waddr <= {r_cur, r_loc};
        r_wdata <= s_tdata;
        r_loc   <= w_close ? '0
                 : r_loc + SEGMENT_SIZE_W'(1);
      end
      if (w_close) begin
        r_up <= {s_tlast, r_cur};
      end
    end
  end

  assign s_tready           = w_tready;
  assign b_wen              = r_wen;
  assign b_waddr            = r_waddr;
  assign b_wdata            = r_wdata;
  assign used_pointer       = r_up;
  assign used_pointer_valid = r_up_valid;
  assign free_count         = r_count;
  assign init_done          = r_init_done;
  assign err                = r_err;

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_one_pop: assert (!(w_pop && r_pop_inflight));
      a_up_wen: assert (!used_pointer_valid || b_wen);
      a_ovf_drop: assert (!(w_ovf && !w_pop)
                          || (w_count_n == r_count));
    end
  end

endmodule

// File: tb/tb_buffer_write.sv
// tb_buffer_write: directed vectors, corner sequences and a
// random run checked against a pointer-queue model.
module tb_buffer_write;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_tdata = '0;
  logic       s_tvalid = 1'b0;
  logic       s_tlast = 1'b0;
  logic       s_tready;
  logic       b_wen;
  logic [3:0] b_waddr;
  logic [7:0] b_wdata;
  logic [2:0] used_pointer;
  logic       used_pointer_valid;
  logic [1:0] freed_pointer = '0;
  logic       freed_pointer_valid = 1'b0;
  logic [2:0] free_count;
  logic       init_done;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;

  buffer_write #(
    .SEGMENT_SIZE_W(2),
    .BUF_SEG_AW(2),
    .DATA_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_tdata(s_tdata),
    .s_tvalid(s_tvalid),
    .s_tlast(s_tlast),
    .s_tready(s_tready),
    .b_wen(b_wen),
    .b_waddr(b_waddr),
    .b_wdata(b_wdata),
    .used_pointer(used_pointer),
    .used_pointer_valid(used_pointer_valid),
    .freed_pointer(freed_pointer),
    .freed_pointer_valid(freed_pointer_valid),
    .free_count(free_count),
    .init_done(init_done),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: the free list is a plain queue of
  // pointers not yet claimed by a segment, in push order.
  logic [1:0] q_m[$];
  int         init_left = 4;
  bit         m_has_cur = 0;
  logic [1:0] m_cur = '0;
  logic [1:0] m_loc = '0;
  bit         e_wen = 0;
  bit         e_uv = 0;
  bit         e_idone = 0;
  bit         e_err = 0;
  logic [3:0] e_addr = '0;
  logic [7:0] e_data = '0;
  logic [2:0] e_u = '0;
  bit         exp_ovf = 0;

  always @(negedge clk) begin
    chk("mon_wen", b_wen, e_wen);
    if (e_wen) begin
      chk("mon_waddr", b_waddr, e_addr);
      chk("mon_wdata", b_wdata, e_data);
    end
    chk("mon_uv", used_pointer_valid, e_uv);
    if (e_uv) chk("mon_used", used_pointer, e_u);
    chk("mon_init_done", init_done, e_idone);
    chk("mon_err", err, e_err);
    if (init_left > 0) chk("mon_init_rdy", s_tready, 0);
    if (rst) begin
      q_m.delete();
      for (int i = 0; i < 4; i++) q_m.push_back(2'(i));
      init_left = 4;
      m_has_cur = 0;
      m_loc     = '0;
      e_wen     = 0;
      e_uv      = 0;
      e_idone   = 0;
      e_err     = 0;
    end else begin
      e_wen = 0;
      e_uv  = 0;
      if (s_tvalid && s_tready) begin
        if (!m_has_cur) begin
          chk("mon_ptr_avail", q_m.size() > 0, 1);
          if (q_m.size() > 0) m_cur = q_m.pop_front();
          m_has_cur = 1;
        end
        e_wen  = 1;
        e_addr = {m_cur, m_loc};
        e_data = s_tdata;
        if (s_tlast || m_loc == 2'd3) begin
          e_uv      = 1;
          e_u       = {s_tlast, m_cur};
          m_has_cur = 0;
          m_loc     = '0;
        end else begin
          m_loc = m_loc + 2'd1;
        end
      end
      if (freed_pointer_valid) begin
        if (init_left > 0 || exp_ovf) e_err = 1;
        else q_m.push_back(freed_pointer);
      end
      if (init_left > 0) begin
        init_left--;
        if (init_left == 0) e_idone = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit free_in_init);
    rst = 1'b1;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    freed_pointer_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("init_rdy_lo", s_tready, 0);
      chk("init_done_lo", init_done, 0);
      if (free_in_init && k == 1) begin
        freed_pointer = 2'd3;
        freed_pointer_valid = 1'b1;
      end
      tick();
      freed_pointer_valid = 1'b0;
    end
    chk("init_done_hi", init_done, 1);
    chk("init_count", free_count, 4);
    tick();
    tick();
    chk("first_rdy", s_tready, 1);
    for (int n = 0; n < 20 && free_count != 3'd2; n++) tick();
    chk("prefetch_count", free_count, 2);
    tick();
  endtask

  typedef struct {
    bit         rb;
    logic [7:0] d;
    bit         l;
    logic [3:0] a;
    bit         uv;
    logic [2:0] u;
  } vec_t;

  function automatic vec_t mk(bit rb, logic [7:0] d, bit l,
                              logic [3:0] a, bit uv,
                              logic [2:0] u);
    mk.rb = rb;
    mk.d  = d;
    mk.l  = l;
    mk.a  = a;
    mk.uv = uv;
    mk.u  = u;
  endfunction

  vec_t vec[16];
  logic [1:0] rq[$];

  initial begin
    #100000;
    $display("FAIL watchdog: sim time %0t", $time);
    $fatal(1);
  end

  initial begin
    int acc;
    int idx;
    int n;

    vec[0]  = mk(1, 8'h11, 0, 4'd0, 0, 3'b000);
    vec[1]  = mk(0, 8'h22, 0, 4'd1, 0, 3'b000);
    vec[2]  = mk(0, 8'h33, 1, 4'd2, 1, 3'b100);
    vec[3]  = mk(1, 8'ha0, 0, 4'd0, 0, 3'b000);
    vec[4]  = mk(0, 8'ha1, 0, 4'd1, 0, 3'b000);
    vec[5]  = mk(0, 8'ha2, 0, 4'd2, 0, 3'b000);
    vec[6]  = mk(0, 8'ha3, 0, 4'd3, 1, 3'b000);
    vec[7]  = mk(0, 8'ha4, 0, 4'd4, 0, 3'b000);
    vec[8]  = mk(0, 8'ha5, 0, 4'd5, 0, 3'b000);
    vec[9]  = mk(0, 8'ha6, 0, 4'd6, 0, 3'b000);
    vec[10] = mk(0, 8'ha7, 0, 4'd7, 1, 3'b001);
    vec[11] = mk(0, 8'ha8, 1, 4'd8, 1, 3'b110);
    vec[12] = mk(1, 8'h5a, 0, 4'd0, 0, 3'b000);
    vec[13] = mk(0, 8'h5b, 0, 4'd1, 0, 3'b000);
    vec[14] = mk(0, 8'h5c, 0, 4'd2, 0, 3'b000);
    vec[15] = mk(0, 8'h5d, 1, 4'd3, 1, 3'b100);

    for (int i = 0; i < 16; i++) begin
      if (vec[i].rb) do_reset(0);
      s_tdata  = vec[i].d;
      s_tlast  = vec[i].l;
      s_tvalid = 1'b1;
      chk("vec_rdy", s_tready, 1);
      tick();
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      chk("vec_wen", b_wen, 1);
      chk("vec_waddr", b_waddr, vec[i].a);
      chk("vec_wdata", b_wdata, vec[i].d);
      chk("vec_uv", used_pointer_valid, vec[i].uv);
      if (vec[i].uv) chk("vec_used", used_pointer, vec[i].u);
    end
    tick();

    // exhaustion, then refill from a single freed pointer
    do_reset(0);
    acc = 0;
    s_tvalid = 1'b1;
    for (n = 0; n < 100 && acc < 16; n++) begin
      s_tdata = 8'($urandom);
      s_tlast = (acc == 15);
      if (s_tready) acc++;
      tick();
    end
    s_tlast = 1'b0;
    chk("exh_beats", acc, 16);
    tick();
    tick();
    chk("exh_rdy", s_tready, 0);
    chk("exh_count", free_count, 0);
    freed_pointer = 2'd2;
    freed_pointer_valid = 1'b1;
    tick();
    freed_pointer_valid = 1'b0;
    n = 1;
    while (!s_tready && n < 3) begin
      tick();
      n++;
    end
    chk("refill_rdy", s_tready, 1);
    s_tdata = 8'h7e;
    tick();
    s_tvalid = 1'b0;
    chk("refill_wen", b_wen, 1);
    chk("refill_waddr", b_waddr, 4'd8);

    // freed pointer during INIT
    do_reset(1);
    chk("err_init", err, 1);

    // overflow of a full free list
    do_reset(0);
    chk("err_clear", err, 0);
    freed_pointer = 2'd0;
    freed_pointer_valid = 1'b1;
    tick();
    freed_pointer = 2'd1;
    tick();
    freed_pointer_valid = 1'b0;
    chk("fill_count", free_count, 4);
    chk("fill_no_err", err, 0);
    exp_ovf = 1;
    freed_pointer = 2'd3;
    freed_pointer_valid = 1'b1;
    tick();
    freed_pointer_valid = 1'b0;
    exp_ovf = 0;
    chk("ovf_err", err, 1);
    chk("ovf_count", free_count, 4);

    // reset in the middle of a packet
    do_reset(0);
    s_tdata = 8'h41;
    s_tvalid = 1'b1;
    tick();
    s_tdata = 8'h42;
    tick();
    s_tvalid = 1'b0;
    chk("mid_uv", used_pointer_valid, 0);
    do_reset(0);
    chk("mid_after_uv", used_pointer_valid, 0);
    s_tdata = 8'h99;
    s_tvalid = 1'b1;
    tick();
    s_tvalid = 1'b0;
    chk("mid_first_wen", b_wen, 1);
    chk("mid_first_waddr", b_waddr, 4'd0);
    chk("mid_first_wdata", b_wdata, 8'h99);

    // random traffic with a read side that frees closed segments
    do_reset(0);
    rq.delete();
    for (int c = 0; c < 800; c++) begin
      s_tvalid = ($urandom_range(0, 3) != 0);
      s_tlast  = ($urandom_range(0, 4) == 0);
      s_tdata  = 8'($urandom);
      if (used_pointer_valid) rq.push_back(used_pointer[1:0]);
      freed_pointer_valid = 1'b0;
      if (rq.size() > 0 && $urandom_range(0, 2) == 0) begin
        idx = $urandom_range(0, rq.size() - 1);
        freed_pointer = rq[idx];
        rq.delete(idx);
        freed_pointer_valid = 1'b1;
      end
      tick();
    end
    s_tvalid = 1'b0;
    freed_pointer_valid = 1'b0;
    tick();
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/buffer_write.md
Name: buffer_write

Overview:
- Write-side companion of the segmented packet buffer.
- Accepts an AXI-stream style packet input and takes segment pointers from an internal free-pointer list.
- Writes each beat into the shared buffer RAM at {segment pointer, location}.
- Pushes each closed segment to the read side as a used pointer; the top bit marks end of packet.
- Segments released by the read side return to the free list through the freed_pointer interface.

Parameters:
- SEGMENT_SIZE_W, 10: log2 of beats per segment.
- BUF_SEG_AW, 10: log2 of number of segments.
- ADDR_WIDTH, BUF_SEG_AW+SEGMENT_SIZE_W: buffer RAM address width.
- DATA_WIDTH, 64: beat width.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- s_tdata  in  DATA_WIDTH  beat data.
- s_tvalid  in  1  beat valid.
- s_tlast  in  1  last beat of packet.
- s_tready  out  1  beat accepted when s_tvalid&&s_tready.
- b_wen  out  1  buffer RAM write enable.
- b_waddr  out  ADDR_WIDTH  buffer RAM write address.
- b_wdata  out  DATA_WIDTH  buffer RAM write data.
- used_pointer  out  BUF_SEG_AW+1  closed segment; bit[BUF_SEG_AW] = tlast.
- used_pointer_valid  out  1  one-cycle push strobe.
- freed_pointer  in  BUF_SEG_AW  segment returned by read side.
- freed_pointer_valid  in  1  return strobe.
- free_count  out  BUF_SEG_AW+1  entries currently in free list.
- init_done  out  1  free list initialised.
- err  out  1  sticky: free-list overflow, or free push during INIT.

Behaviour:
- Reset (rst high at a clk edge):
  - Outputs: s_tready, b_wen, used_pointer_valid, init_done, err = 0.
  - Buses b_waddr, b_wdata, used_pointer = 0; free_count = 0.
  - Free list emptied; cur_valid and nxt_valid = 0.
  - Reset mid-packet discards the partial segment silently; no used_pointer is pushed for it.
- Free list: internal FIFO, depth 2^BUF_SEG_AW, 1-cycle read latency.
- FSM states INIT, RUN.
- INIT:
  - Pushes 0,1,...,2^BUF_SEG_AW-1 on consecutive cycles starting the first cycle after reset deasserts.
  - Then init_done=1, state RUN, free_count=2^BUF_SEG_AW.
  - freed_pointer_valid during INIT is dropped and sets err.
- Prefetch (RUN):
  - Two pointer registers, cur and nxt.
  - A pop is issued when (!cur_valid || !nxt_valid), the list is non-empty, and no pop is in flight (max one outstanding).
  - Popped data fills cur if empty, else nxt.
- s_tready = RUN && cur_valid (combinational from registers).
- On accept:
  - Next cycle: b_wen=1, b_waddr={cur, loc}, b_wdata=s_tdata (1-cycle registered latency).
  - loc increments by 1.
- Segment close, on the accepted beat where s_tlast=1 or loc==all-ones:
  - Next cycle: used_pointer={s_tlast, cur} with used_pointer_valid=1, in the same cycle as the final b_wen.
  - Exactly one push even if both conditions hold.
  - loc <= 0.
  - If nxt_valid: cur<=nxt, nxt_valid<=0, no bubble.
  - Otherwise cur_valid<=0 and s_tready drops until refill.
- Empty list, no cur: s_tready=0 until a freed pointer arrives.
  - The freed pointer is pushed the cycle after its strobe, popped the cycle after that, and cur loads the following cycle.
  - s_tready returns ≤3 cycles after the freed_pointer_valid strobe.
- Simultaneous push (freed) and pop is legal: free_count unchanged, FIFO data correct.
- Push when full: dropped, err=1; also covered by an assertion.
- free_count counts FIFO contents only, excluding cur/nxt; +1 per push, -1 per pop.
- Assertions:
  - At most one pop outstanding.
  - used_pointer_valid implies b_wen in the same cycle.

Test Plan (SEGMENT_SIZE_W=2, BUF_SEG_AW=2, DATA_WIDTH=8):
1. Reset init:
   - Release rst at cycle 0 → s_tready=0 for cycles 0-3; init_done=1 at cycle 4.
   - cur=0 loaded by cycle 6 with s_tready=1; free_count=2 once nxt=1 is loaded.
2. 3-beat packet, tlast on beat 3:
   - b_waddr 0,1,2 with matching data.
   - Single used_pointer=3'b100, in the cycle of the third b_wen.
3. 9-beat packet, continuous s_tvalid:
   - b_waddr 0-3, 4-7, 8 with no s_tready gaps at segment boundaries.
   - used_pointer 3'b000, 3'b001, 3'b110.
4. Exact-fit packet, 4 beats with tlast on beat 4:
   - Exactly one push, used_pointer=3'b100.
5. Exhaustion:
   - Stream 16 beats without frees → s_tready low after beat 16, free_count=0.
   - Pulse freed_pointer=2 → s_tready high within 3 cycles; next beat writes b_waddr=8.
6. Errors and mid-packet reset:
   - Freed push during INIT → err=1.
   - Push with free list full → err=1, free_count stays 4.
   - rst after 2 beats of a packet → no used_pointer_valid for that segment; after re-init the first write goes to b_waddr=0.
